// File: rtl/spi_oled_fifo_if.sv
// Control-bus bundle for spi_oled_fifo: the PicoSoC ctrl_wr/ctrl_rd/ctrl_done
// request/complete handshake with byte address and 32-bit data paths.
interface spi_oled_fifo_if;
   logic        ctrl_wr;
   logic        ctrl_rd;
   logic [7:0]  ctrl_addr;
   logic [31:0] ctrl_wdat;
   logic [31:0] ctrl_rdat;
   logic        ctrl_done;

   modport master (
      output ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
      input  ctrl_rdat, ctrl_done
   );

   modport slave (
      input  ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
      output ctrl_rdat, ctrl_done
   );
endinterface

// File: rtl/spi_oled_fifo.sv
// spi_oled_fifo: write-only SPI master for OLED/LCD panels. Entries of
// {WIDE, D/C, data} are queued in a TX FIFO and shifted out MSB first, with
// optional automatic chip-select framing that chains back-to-back entries.
module spi_oled_fifo #(
   parameter int FIFO_DEPTH = 16,
   parameter int PRESCALE_W = 8
) (
   input  logic           clk,
   input  logic           resetn,
   spi_oled_fifo_if.slave bus,
   output logic           spi_sclk,
   output logic           spi_mosi,
   output logic           spi_cs,
   output logic           spi_dc,
   output logic           spi_rst
);
   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] LP_FULL = (AW+1)'(FIFO_DEPTH);

   localparam logic [7:0] A_PRESCALE = 8'h00;
   localparam logic [7:0] A_CTRL     = 8'h04;
   localparam logic [7:0] A_TXDATA   = 8'h08;
   localparam logic [7:0] A_STATUS   = 8'h0C;

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

   // Register file and bus handshake
   logic [PRESCALE_W-1:0] r_prescale;
   logic [4:0]            r_ctrl;        // {RST, AUTO_CS, CS, CPOL, CPHA}
   logic                  r_done;
   logic [31:0]           r_rdat;

   // FIFO
   logic [17:0]           r_mem [FIFO_DEPTH];
   logic [AW:0]           r_wr_ptr;
   logic [AW:0]           r_rd_ptr;

   // Engine
   state_t                r_state;
   state_t                w_state_nxt;
   logic [PRESCALE_W-1:0] r_div;
   logic [PRESCALE_W-1:0] r_p;
   logic                  r_cpol, r_cpha, r_wide, r_auto, r_half;
   logic [3:0]            r_bit;
   logic [15:0]           r_sh;
   logic                  r_sclk, r_mosi, r_cs, r_dc;

   logic                  w_wr, w_rd, w_push, w_pop, w_flush, w_done_nxt;
   logic [AW:0]           w_level;
   logic                  w_empty, w_full, w_busy;
   logic [4:0]            w_ctrl_nxt;
   logic [17:0]           w_head;
   logic [15:0]           w_head_data;
   logic                  w_tick, w_last_bit, w_auto_eff;
   logic [31:0]           w_rdata;
   logic                  w_unused;

   // A held request is taken only while no completion pulse is outstanding.
   assign w_wr        = bus.ctrl_wr & ~r_done;
   assign w_rd        = bus.ctrl_rd & ~bus.ctrl_wr & ~r_done;
   assign w_level     = r_wr_ptr - r_rd_ptr;
   assign w_empty     = (w_level == '0);
   assign w_full      = (w_level == LP_FULL);
   assign w_busy      = ~w_empty | (r_state != S_IDLE);
   // A push into a full FIFO stalls, unless the engine frees a slot this cycle.
   assign w_push      = w_wr && (bus.ctrl_addr == A_TXDATA) && (!w_full || w_pop);
   assign w_done_nxt  = w_rd || (w_wr && (bus.ctrl_addr != A_TXDATA)) || w_push;
   assign w_flush     = w_wr && (bus.ctrl_addr == A_STATUS) && bus.ctrl_wdat[0];
   assign w_ctrl_nxt  = (w_wr && (bus.ctrl_addr == A_CTRL)) ? bus.ctrl_wdat[4:0] : r_ctrl;
   assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
   // Narrow frames are left-aligned so the shifter always emits bit 15 first.
   assign w_head_data = w_head[17] ? w_head[15:0] : {w_head[7:0], 8'h00};
   assign w_tick      = (r_div == r_p);
   assign w_last_bit  = (r_bit == (r_wide ? 4'd15 : 4'd7));
   // In IDLE the live CTRL decides CS; inside a frame the value latched at pop.
   assign w_auto_eff  = (r_state == S_IDLE) ? r_ctrl[3] : r_auto;
   assign w_unused    = ^bus.ctrl_wdat[31:18];

   // Engine state register
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Engine next state and pop decision
   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_SETUP;
            end
         end
         S_SETUP: if (w_tick) w_state_nxt = S_SHIFT;
         S_SHIFT: begin
            if (w_tick && r_half && w_last_bit) begin
               if (!w_empty && r_auto) begin
                  w_pop       = 1'b1;        // chain: next frame starts without SETUP
                  w_state_nxt = S_SHIFT;
               end else begin
                  w_state_nxt = S_HOLD;
               end
            end
         end
         S_HOLD:  if (w_tick) w_state_nxt = S_GAP;
         S_GAP:   if (w_tick) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Register writes, read data capture and completion pulse
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_prescale <= '0;
         r_ctrl     <= 5'h13;
         r_done     <= 1'b0;
         r_rdat     <= '0;
      end else begin
         r_done <= w_done_nxt;
         r_rdat <= w_rd ? w_rdata : '0;
         if (w_wr && (bus.ctrl_addr == A_PRESCALE)) r_prescale <= bus.ctrl_wdat[PRESCALE_W-1:0];
         r_ctrl <= w_ctrl_nxt;
      end
   end

   // Read multiplexer
   always_comb begin
      w_rdata = '0;
      case (bus.ctrl_addr)
         A_PRESCALE: w_rdata = 32'(r_prescale);
         A_CTRL:     w_rdata = {27'd0, r_ctrl};
         A_STATUS:   w_rdata = {16'd0, 8'(w_level), 5'd0, w_full, w_empty, w_busy};
         default:    w_rdata = '0;
      endcase
   end

   // FIFO pointers; FLUSH discards queued entries but not the frame already popped
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push)      r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_flush)     r_rd_ptr <= r_wr_ptr;
         else if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // FIFO storage
   // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= bus.ctrl_wdat[17:0];
   end

   // Shift engine datapath: half-period divider, bit shifter and pin drivers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_div  <= '0;
         r_p    <= '0;
         r_cpol <= 1'b1;
         r_cpha <= 1'b1;
         r_wide <= 1'b0;
         r_auto <= 1'b0;
         r_half <= 1'b0;
         r_bit  <= '0;
         r_sh   <= '0;
         r_sclk <= 1'b1;
         r_mosi <= 1'b0;
         r_cs   <= 1'b1;
         r_dc   <= 1'b0;
      end else begin
         r_div <= (r_state == S_IDLE || w_tick) ? '0 : r_div + PRESCALE_W'(1);

         if (w_pop) begin
            r_p    <= r_prescale;
            r_cpol <= r_ctrl[1];
            r_cpha <= r_ctrl[0];
            r_auto <= r_ctrl[3];
            r_wide <= w_head[17];
            r_dc   <= w_head[16];
            r_half <= 1'b0;
            r_bit  <= '0;
            r_sclk <= r_ctrl[1];
            if (!r_ctrl[0]) begin
               r_mosi <= w_head_data[15];
               r_sh   <= {w_head_data[14:0], 1'b0};
            end else begin
               r_sh   <= w_head_data;
            end
         end else if (r_state == S_IDLE) begin
            r_sclk <= w_ctrl_nxt[1];
         end else if (r_state == S_SHIFT && w_tick) begin
            r_half <= ~r_half;
            r_sclk <= r_half ? r_cpol : ~r_cpol;
            if (r_half) r_bit <= r_bit + 4'd1;
            // CPHA=0 moves data on the trailing edge, CPHA=1 on the leading edge.
            if (r_half != r_cpha) begin
               r_mosi <= r_sh[15];
               r_sh   <= {r_sh[14:0], 1'b0};
            end
         end

         if (w_pop)
            r_cs <= r_ctrl[3] ? 1'b0 : r_ctrl[2];
         else if (!w_auto_eff)
            r_cs <= r_ctrl[2];
         else if (r_state == S_IDLE || (r_state == S_HOLD && w_tick))
            r_cs <= 1'b1;
      end
   end

   assign bus.ctrl_done = r_done;
   assign bus.ctrl_rdat = r_rdat;
   assign spi_sclk      = r_sclk;
   assign spi_mosi      = r_mosi;
   assign spi_cs        = r_cs;
   assign spi_dc        = r_dc;
   assign spi_rst       = r_ctrl[4];
endmodule

// File: tb/tb_spi_oled_fifo.sv
// Self-checking bench for spi_oled_fifo: directed scenarios plus randomized
// bursts, with a panel-side monitor comparing received frames to a queue model.
module tb_spi_oled_fifo;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [15:0] data;
      logic        dc;
      logic        wide;
   } ent_t;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   logic spi_sclk, spi_mosi, spi_cs, spi_dc, spi_rst;

   spi_oled_fifo_if bus ();

   spi_oled_fifo #(.FIFO_DEPTH(DEPTH), .PRESCALE_W(8)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .bus      (bus),
      .spi_sclk (spi_sclk),
      .spi_mosi (spi_mosi),
      .spi_cs   (spi_cs),
      .spi_dc   (spi_dc),
      .spi_rst  (spi_rst)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: entries pushed and not yet seen on the wire, plus the
   // mode the panel is expected to be talking in.
   ent_t exp_q[$];
   int   m_p    = 0;
   bit   m_cpol = 1'b1;
   bit   m_cpha = 1'b1;

   // Panel-side monitor
   int          cyc = 0, last_edge = -1, cs_run = 0, cs_low_len = 0;
   int          cs_rises = 0, frames = 0, mon_nb = 0;
   logic [15:0] mon_sh = '0;
   logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0, prev_dc = 1'b0;

   always @(negedge clk) begin
      if (!resetn) begin
         mon_nb = 0; mon_sh = '0; cs_run = 0; last_edge = -1;
         prev_cs = 1'b1; prev_sclk = 1'b1; prev_mosi = 1'b0; prev_dc = 1'b0;
      end else begin
         cyc++;
         if (!spi_cs && !prev_cs && (spi_sclk != prev_sclk)) begin
            if (last_edge >= 0) check("half_period", 32'(cyc - last_edge), 32'(m_p + 1));
            last_edge = cyc;
            if (spi_sclk == (m_cpol == m_cpha)) begin
               if (exp_q.size() == 0) begin
                  check("bit_without_entry", 32'(exp_q.size()), 32'd1);
               end else begin
                  check("dc_level", 32'(prev_dc), 32'(exp_q[0].dc));
                  mon_sh = {mon_sh[14:0], prev_mosi};
                  mon_nb++;
                  if (mon_nb == (exp_q[0].wide ? 16 : 8)) begin
                     check("frame_data",
                           exp_q[0].wide ? 32'(mon_sh) : 32'(mon_sh[7:0]),
                           exp_q[0].wide ? 32'(exp_q[0].data) : 32'(exp_q[0].data[7:0]));
                     exp_q.delete(0);
                     mon_nb = 0;
                     frames++;
                  end
               end
            end
         end
         if (!spi_cs) begin
            cs_run++;
         end else if (!prev_cs) begin
            cs_low_len = cs_run;
            cs_run     = 0;
            cs_rises++;
            last_edge  = -1;
            mon_nb     = 0;
         end
         prev_cs   = spi_cs;
         prev_sclk = spi_sclk;
         prev_mosi = spi_mosi;
         prev_dc   = spi_dc;
      end
   end

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d, output int lat);
      bus.ctrl_addr = a;
      bus.ctrl_wdat = d;
      bus.ctrl_wr   = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!bus.ctrl_done && lat < 3000);
      if (!bus.ctrl_done) check("write_timeout", 32'(bus.ctrl_done), 32'd1);
      bus.ctrl_wr = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
      int n = 0;
      bus.ctrl_addr = a;
      bus.ctrl_rd   = 1'b1;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bus.ctrl_done && n < 100);
      if (!bus.ctrl_done) check("read_timeout", 32'(bus.ctrl_done), 32'd1);
      d = bus.ctrl_rdat;
      bus.ctrl_rd = 1'b0;
   endtask

   task automatic push(input logic [17:0] v, output int lat);
      ent_t e;
      e.data = v[15:0];
      e.dc   = v[16];
      e.wide = v[17];
      exp_q.push_back(e);
      bus_write(8'h08, {14'd0, v}, lat);
   endtask

   task automatic set_mode(input int p, input bit cpol, input bit cpha);
      int lat;
      bus_write(8'h00, 32'(p), lat);
      bus_write(8'h04, 32'h1C | (32'(cpol) << 1) | 32'(cpha), lat);
      m_p = p; m_cpol = cpol; m_cpha = cpha;
      check("sclk_idle", 32'(spi_sclk), 32'(cpol));
   endtask

   task automatic wait_idle();
      logic [31:0] s;
      int n = 0;
      do begin
         bus_read(8'h0C, s);
         n++;
      end while (s[0] && n < 3000);
      if (s[0]) check("idle_timeout", 32'(s[0]), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_pins(input string tag);
      check({tag, "_cs"},   32'(spi_cs),        32'd1);
      check({tag, "_sclk"}, 32'(spi_sclk),      32'd1);
      check({tag, "_mosi"}, 32'(spi_mosi),      32'd0);
      check({tag, "_dc"},   32'(spi_dc),        32'd0);
      check({tag, "_rst"},  32'(spi_rst),       32'd1);
      check({tag, "_done"}, 32'(bus.ctrl_done), 32'd0);
      check({tag, "_rdat"}, bus.ctrl_rdat,      32'd0);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] r;
      int          lat;
      int          lats[6];
      int          f0, r0, n;

      bus.ctrl_wr = 1'b0; bus.ctrl_rd = 1'b0; bus.ctrl_addr = '0; bus.ctrl_wdat = '0;

      // Reset state
      #23;
      check_reset_pins("reset");
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1;
      bus_read(8'h04, r); check("ctrl_reset", r, 32'h13);
      bus_read(8'h00, r); check("prescale_reset", r, 32'h0);
      bus_read(8'h0C, r); check("status_reset", r, 32'h2);
      bus_read(8'h40, r); check("unmapped_read", r, 32'h0);
      bus_read(8'h08, r); check("txdata_read", r, 32'h0);
      bus_write(8'h04, 32'h03, lat);
      check("rst_pin_low", 32'(spi_rst), 32'd0);
      bus_write(8'h04, 32'h1B, lat);
      check("rst_pin_high", 32'(spi_rst), 32'd1);

      // Mode 0, P=0, single narrow command
      set_mode(0, 1'b0, 1'b0);
      push(18'h000A5, lat);
      wait_idle();
      check("cs_len_mode0", 32'(cs_low_len), 32'd18);

      // Mode 3, P=3, wide data with DC=1
      set_mode(3, 1'b1, 1'b1);
      push(18'h31234, lat);
      wait_idle();
      check("cs_len_wide", 32'(cs_low_len), 32'd136);

      // Back-to-back pushes into a 4-deep FIFO with P=7
      set_mode(7, 1'b0, 1'b0);
      r0 = cs_rises; f0 = frames;
      for (int i = 0; i < 6; i++) push(18'(8'h30 + i), lats[i]);
      for (int i = 0; i < 5; i++) check("push_not_stalled", 32'(lats[i] <= 2), 32'd1);
      check("push6_stalled", 32'(lats[5] > 2), 32'd1);
      wait_idle();
      check("burst_frames", 32'(frames - f0), 32'd6);
      check("burst_cs_rises", 32'(cs_rises - r0), 32'd1);
      check("burst_cs_len", 32'(cs_low_len), 32'd784);
      bus_read(8'h0C, r); check("status_after_burst", r, 32'h2);

      // Command then data: DC changes at the second pop, CS stays low
      set_mode(1, 1'b0, 1'b0);
      r0 = cs_rises; f0 = frames;
      push(18'h000AF, lat);
      push(18'h10055, lat);
      wait_idle();
      check("cmd_data_frames", 32'(frames - f0), 32'd2);
      check("cmd_data_cs_rises", 32'(cs_rises - r0), 32'd1);
      check("cmd_data_cs_len", 32'(cs_low_len), 32'd68);

      // Reset pulse in the middle of a frame
      set_mode(2, 1'b0, 1'b1);
      push(18'h101F0, lat);
      n = 0;
      while (spi_cs && n < 200) begin @(posedge clk); #1; n++; end
      repeat (9) @(posedge clk);
      @(negedge clk); #2;
      resetn = 1'b0;
      #1;
      check_reset_pins("midframe_reset");
      exp_q.delete();
      #20;
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1;
      bus_read(8'h0C, r); check("status_after_reset", r, 32'h2);
      bus_write(8'h04, 32'h1B, lat);
      m_cpol = 1'b1; m_cpha = 1'b1; m_p = 0;
      set_mode(0, 1'b0, 1'b0);
      f0 = frames;
      push(18'h00055, lat);
      wait_idle();
      check("frame_after_reset", 32'(frames - f0), 32'd1);
      check("cs_len_after_reset", 32'(cs_low_len), 32'd18);

      // FLUSH while frame 1 of 3 is on the wire
      set_mode(1, 1'b0, 1'b0);
      r0 = cs_rises; f0 = frames;
      push(18'h00011, lat);
      push(18'h00022, lat);
      push(18'h00033, lat);
      n = 0;
      while (spi_cs && n < 200) begin @(posedge clk); #1; n++; end
      repeat (6) @(posedge clk);
      #1;
      bus_write(8'h0C, 32'h1, lat);
      while (exp_q.size() > 1) exp_q.delete(exp_q.size() - 1);
      wait_idle();
      check("flush_frames", 32'(frames - f0), 32'd1);
      check("flush_cs_rises", 32'(cs_rises - r0), 32'd1);
      check("flush_cs_len", 32'(cs_low_len), 32'd36);
      bus_read(8'h0C, r); check("status_after_flush", r, 32'h2);

      // Randomized bursts in random modes and prescales
      for (int b = 0; b < 4; b++) begin
         set_mode(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         f0 = frames;
         for (int i = 0; i < 8; i++) begin
            push(18'($urandom_range(0, 32'h3FFFF)), lat);
            repeat ($urandom_range(0, 40)) @(posedge clk);
            #1;
         end
         wait_idle();
         check("random_frames", 32'(frames - f0), 32'd8);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
